fp_mul_arbiter: RTL

- Shares one single-precision (IEEE-754 layout) multiply datapath among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Datapath is pipelined into a 2-register stream: S1 holds operands, S2 holds the result.
- Returns results on one shared response channel, tagged with the requester index, with backpressure. Sits between the team's compute clients and the FP multiply core.

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/fp_mul_core.sv | 19 +
 rtl/fp_mul_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the arbitrated single-precision multiplier.
package fp_mul_pkg;

  localparam int unsigned EXP_BIAS = 127;
  // Widest requester tag supported (NREQ up to 8)
  localparam int unsigned ID_MAXW  = 3;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    fp32_t              a;
    fp32_t              b;
    logic [ID_MAXW-1:0] id;
  } s1_rec_t;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational truncating FP32 multiply; no special-casing of zero/denormal/inf/NaN.
module fp_mul_core
  import fp_mul_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t p_o
);

  // Upper product bits [47:23]; everything below is truncated away
  logic [24:0] p_hi;

  assign p_hi = 25'((48'({1'b1, a_i.mant}) * 48'({1'b1, b_i.mant})) >> 23);

  assign p_o.sign = a_i.sign ^ b_i.sign;
  assign p_o.mant = p_hi[24] ? p_hi[23:1] : p_hi[22:0];
  assign p_o.exp  = 8'(10'(a_i.exp) + 10'(b_i.exp) - 10'(EXP_BIAS) + 10'(p_hi[24]));

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one two-stage FP32 multiply pipeline among NREQ requesters.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_data,
  output logic               busy
);

  localparam int unsigned SCANW = IDW + 1;

  s1_rec_t         s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  fp32_t           s2_data_q, s2_data_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            adv1, adv2;
  logic            found;
  logic            xfer;
  logic [IDW-1:0]  grant_idx;
  logic [SCANW-1:0] scan_idx;
  fp32_t           sel_a, sel_b;
  fp32_t           core_p;

  assign adv2 = !s2_valid_q || rsp_ready;
  assign adv1 = !s1_valid_q || adv2;

  // First valid requester starting at rr_ptr, wrapping mod NREQ
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = SCANW'(rr_ptr_q) + SCANW'(k);
      if (scan_idx >= SCANW'(NREQ)) begin
        scan_idx = scan_idx - SCANW'(NREQ);
      end
      if (!found && req_valid[scan_idx[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_idx[IDW-1:0];
      end
    end
  end

  assign xfer      = found && adv1 && rst_n;
  assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = fp32_t'(req_a[32*i +: 32]);
        sel_b = fp32_t'(req_b[32*i +: 32]);
      end
    end
  end

  fp_mul_core u_core (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (core_p)
  );

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    s2_valid_d = s2_valid_q;
    rr_ptr_d   = rr_ptr_q;

    if (xfer) begin
      s1_d.a     = sel_a;
      s1_d.b     = sel_b;
      s1_d.id    = ID_MAXW'(grant_idx);
      s1_valid_d = 1'b1;
      rr_ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      s2_data_d  = core_p;
      s2_id_d    = IDW'(s1_q.id);
      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      s2_valid_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      s2_valid_q <= s2_valid_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule
